// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
//   Handshake bundle for the bit-serial adder controller.
//   Operand side : in_valid / in_ready, addends a and b.
//   Result side  : out_valid / out_ready, sum and cout.
//   Status       : busy (operation in flight or result pending).
//   master = producer/consumer (e.g. testbench), slave = serial_add_ctrl.
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Adds two WIDTH-bit operands one bit per clock with a single shared
//   full adder, LSB first. An accepted operand pair produces its result
//   exactly WIDTH rising edges later; the result is held until taken.
//
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : serial_add_ctrl_if.slave
//            in_valid/in_ready/a/b       operand handshake (accept in IDLE)
//            out_valid/out_ready/sum/cout result handshake (release in DONE)
//            busy                         high in RUN or DONE
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);

  // Wide enough to reach WIDTH itself, so the final increment never wraps.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_next;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_s1;
  logic             w_c1;
  logic             w_bit;
  logic             w_carry_next;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Shared full adder built from two half-add stages on the operand LSBs.
  assign w_s1         = r_a[0] ^ r_b[0];
  assign w_c1         = r_a[0] & r_b[0];
  assign w_bit        = w_s1 ^ r_carry;
  assign w_carry_next = w_c1 | (w_s1 & r_carry);

  // New bit enters at the MSB so that after WIDTH shifts the LSB-first
  // stream lands in natural bit order.
  always_comb begin
    // NOTE: assign a full default first in every combinational block; any
    // bit left unassigned on some path would be inferred as a latch.
    w_sum_next            = r_sum >> 1;
    w_sum_next[WIDTH-1]   = w_bit;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_next = RUN;
      RUN:     if (w_last)        w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs, decoded from the state register only ----
  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
    bus.busy      = (r_state == RUN) || (r_state == DONE);
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

  // ---------------- Datapath ----------------
  // Everything is cleared on reset so an aborted operation leaves no trace
  // on sum/cout and the next operation starts from a known carry/count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_next;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_carry_next;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) r_cout <= w_carry_next;
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits, legal range 1..32.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operand pair a/b is valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  addend A, sampled on accept.
REQ-007 SHALL have port: b  input  WIDTH  addend B, sampled on accept.
REQ-008 SHALL have port: out_valid  output  1  sum/cout hold a finished result.
REQ-009 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port: sum  output  WIDTH  result bits, a+b mod 2^WIDTH.
REQ-011 SHALL have port: cout  output  1  carry out of bit WIDTH-1.
REQ-012 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE, with a single bit-serial adder shared across all bit positions.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept on a rising edge with in_valid&&in_ready: latch a and b into shift registers, clear the carry flop and bit counter, and go IDLE->RUN.
REQ-016 SHALL, on each RUN edge, form one full-add bit from two half-add stages: s1=a0^b0, c1=a0&b0, bit=s1^carry, carry_next=c1|(s1&carry).
REQ-017 SHALL, on each RUN edge, shift that bit into sum from the MSB end, shift the operand registers right by 1, and increment the counter.
REQ-018 SHALL, on the RUN edge that processes bit WIDTH-1, load the final carry into cout and go RUN->DONE.
REQ-019 SHALL therefore raise out_valid exactly WIDTH edges after the accept edge, with LSB-first processing.
REQ-020 SHALL hold sum, cout and out_valid stable in DONE until an edge with out_ready=1, then go DONE->IDLE.
REQ-021 SHALL ignore in_valid while in RUN or DONE; there is no accept in the same cycle as result release.
REQ-022 SHALL treat out_ready as don't-care outside DONE.
REQ-023 SHALL, for WIDTH=1, spend exactly one RUN cycle.
REQ-024 SHALL size the counter to ceil(log2(WIDTH+1)) bits with no wrap during a legal operation.
REQ-025 SHALL keep in_ready and out_valid glitch-free, each decoded directly from the state register.

Reset
REQ-026 SHALL, while rst=1 and regardless of clk, force state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, and clear carry, counter and operand registers.
REQ-027 SHALL, on reset asserted mid-RUN or in DONE, discard the operation; no out_valid follows.
REQ-028 SHALL be able to accept operands on the first rising edge after rst deasserts.

Verification
REQ-029 SHALL pass: WIDTH=8, a=0x0F, b=0x01 accepted at edge E0 -> out_valid=1 after E8, sum=0x10, cout=0, busy=1 throughout E1..E8.
REQ-030 SHALL pass: WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, cout=1.
REQ-031 SHALL pass: a=0xA5, b=0x5A, out_ready held 0 for 5 cycles in DONE -> sum=0xFF and cout=0 stable, in_ready=0; out_ready=1 -> IDLE on the next edge, in_ready=1.
REQ-032 SHALL pass: rst pulsed after 3 RUN edges -> in_ready=1, out_valid=0, sum=0, cout=0 immediately; new op a=0x03, b=0x04 -> sum=0x07.
REQ-033 SHALL pass: in_valid held 1 during RUN with changing a/b -> result reflects only the operands latched at acceptance.
REQ-034 SHALL pass: 1000 random back-to-back ops with WIDTH=1, 8 and 32, out_ready randomized -> {cout,sum}==a+b every time, and one result per accept.
